pll_lock_ctrl: RTL and testbench

Sequences the 500 MHz PLL from the 50 MHz reference domain. The block does four things:
- pulses the PLL reset;
- waits for and debounces the PLL lock indication;
- retries on lock timeout;
- holds the downstream measurement logic in reset until the clock is proven stable.

It sits between the board reset, the PLL wrapper's `rst`/`locked` pins, and the reset tree of the frequency-counter datapath.

---
 rtl/pll_lock_ctrl.sv | 151 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Sequences the PLL from the reference clock domain. It pulses the PLL reset,
//   waits for a debounced lock, retries on timeout, and holds the downstream
//   logic in reset until lock has been stable for STABLE_CYCLES cycles.
//
// Ports
//   refclk      in   reference clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL locked pin, asynchronous to refclk
//   restart     in   synchronous restart request (level)
//   pll_rst     out  PLL reset, active-high
//   sys_rst_n   out  downstream reset, active-low
//   ready       out  PLL locked and stable
//   fail        out  retries exhausted
//   retry_cnt   out  retries consumed in the current episode
//   lock_lost   out  one-cycle pulse when lock drops in RUN
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_RESET_PLL | pll_rst high for RST_CYCLES cycles
// ST_WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT for lock
// ST_STABLE    | lock seen, must stay high for STABLE_CYCLES cycles
// ST_RUN       | clock proven, downstream released, ready high
// ST_FAIL      | retries exhausted, parked until restart or rst_n
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       retry_nx;
    logic             lost_nx;
    logic             attempt_failed;
    logic             locked_meta, locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        retry_nx       = retry_cnt;
        lost_nx        = 1'b0;
        attempt_failed = 1'b0;

        case (state)
            ST_RESET_PLL: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_nx = cnt + 1'b1;
                if (locked_s)                  state_nx = ST_STABLE;
                else if (cnt == TIMEOUT_LAST)  attempt_failed = 1'b1;
            end
            ST_STABLE: begin
                cnt_nx = cnt + 1'b1;
                if (!locked_s)                attempt_failed = 1'b1;
                else if (cnt == STABLE_LAST)  state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    lost_nx  = 1'b1;
                    retry_nx = 3'd0;
                    state_nx = ST_RESET_PLL;
                end
            end
            ST_FAIL: ;
            default: state_nx = ST_RESET_PLL;
        endcase

        // A lost lock in STABLE and a WAIT_LOCK timeout share one retry rule;
        // retry_cnt can never pass RETRY_MAX because that value goes to FAIL.
        if (attempt_failed) begin
            if (retry_cnt == RETRY_MAX) begin
                state_nx = ST_FAIL;
            end else begin
                retry_nx = retry_cnt + 3'd1;
                state_nx = ST_RESET_PLL;
            end
        end

        if (restart) begin
            state_nx = ST_RESET_PLL;
            retry_nx = 3'd0;
            lost_nx  = 1'b0;
        end

        // Held restart keeps cnt at 0 even though the state does not change.
        if (restart || (state_nx != state)) cnt_nx = '0;
    end

    // Outputs are decoded from the next state so they move with the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET_PLL;
            cnt       <= '0;
            retry_cnt <= 3'd0;
            lock_lost <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            retry_cnt <= retry_nx;
            lock_lost <= lost_nx;
            pll_rst   <= (state_nx == ST_RESET_PLL) || (state_nx == ST_FAIL);
            sys_rst_n <= (state_nx == ST_RUN);
            ready     <= (state_nx == ST_RUN);
            fail      <= (state_nx == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
module tb_pll_lock_ctrl;

    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int STC = 8;
    localparam int MR  = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail, lock_lost;
    logic [2:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    pll_lock_ctrl #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STC),
        .MAX_RETRY(MR), .CNT_W(16)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
        .restart(restart), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n),
        .ready(ready), .fail(fail), .retry_cnt(retry_cnt),
        .lock_lost(lock_lost)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
        end
    endtask

    // Behavioural model: phases with remaining-cycle budgets, and a
    // two-entry history of the lock pin standing in for the synchronizer.
    // It is stepped at each falling edge with the inputs the next rising
    // edge will sample, after first comparing against the DUT.
    int   m_phase;  // 0 reset pulse, 1 waiting, 2 stability, 3 running, 4 failed
    int   m_left;
    int   m_retry;
    int   m_lost;
    logic m_hist [2];

    task automatic model_reset();
        m_phase = 0; m_left = RST; m_retry = 0; m_lost = 0;
        m_hist[0] = 1'b0; m_hist[1] = 1'b0;
    endtask

    task automatic model_attempt_failed();
        if (m_retry == MR) m_phase = 4;
        else begin
            m_retry = m_retry + 1;
            m_phase = 0;
            m_left  = RST;
        end
    endtask

    task automatic model_step(input logic lk, input logic rs);
        logic ls;
        ls = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = lk;
        m_lost = 0;
        if (rs) begin
            m_phase = 0; m_left = RST; m_retry = 0;
        end else if (m_phase == 0) begin
            m_left--;
            if (m_left == 0) begin m_phase = 1; m_left = TO; end
        end else if (m_phase == 1) begin
            if (ls) begin m_phase = 2; m_left = STC; end
            else begin
                m_left--;
                if (m_left == 0) model_attempt_failed();
            end
        end else if (m_phase == 2) begin
            if (!ls) model_attempt_failed();
            else begin
                m_left--;
                if (m_left == 0) m_phase = 3;
            end
        end else if (m_phase == 3) begin
            if (!ls) begin
                m_lost = 1; m_retry = 0; m_phase = 0; m_left = RST;
            end
        end
    endtask

    always @(negedge refclk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            chk("cyc_pll_rst",   int'(pll_rst),   int'(m_phase == 0 || m_phase == 4));
            chk("cyc_sys_rst_n", int'(sys_rst_n), int'(m_phase == 3));
            chk("cyc_ready",     int'(ready),     int'(m_phase == 3));
            chk("cyc_fail",      int'(fail),      int'(m_phase == 4));
            chk("cyc_retry_cnt", int'(retry_cnt), m_retry);
            chk("cyc_lock_lost", int'(lock_lost), m_lost);
            model_step(pll_locked, restart);
        end
    end

    task automatic tick();
        @(posedge refclk);
        ecnt++;
        #2;
    endtask

    task automatic tick_to(input int n);
        while (ecnt < n) tick();
    endtask

    task automatic do_reset(input logic lk);
        rst_n = 1'b0;
        restart = 1'b0;
        pll_locked = lk;
        @(posedge refclk);
        @(posedge refclk);
        #5;
        rst_n = 1'b1;
        ecnt = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"},   int'(pll_rst),   1);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_ready"},     int'(ready),     0);
        chk({tag, "_fail"},      int'(fail),      0);
        chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
        chk({tag, "_lock_lost"}, int'(lock_lost), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lock present throughout, then loss in RUN, then restart in RUN.
        do_reset(1'b1);
        #1;
        chk_reset_vals("edge0");
        tick_to(3);  chk("s1_pll_rst_e3", int'(pll_rst), 1);
        tick_to(4);  chk("s1_pll_rst_e4", int'(pll_rst), 0);
        tick_to(12); chk("s1_ready_e12", int'(ready), 0);
                     chk("s1_sysrst_e12", int'(sys_rst_n), 0);
        tick_to(13); chk("s1_ready_e13", int'(ready), 1);
                     chk("s1_sysrst_e13", int'(sys_rst_n), 1);
        tick_to(30); pll_locked = 1'b0;
        tick_to(32); chk("s3_ready_e32", int'(ready), 1);
                     chk("s3_lost_e32", int'(lock_lost), 0);
        tick_to(33); chk("s3_lost_e33", int'(lock_lost), 1);
                     chk("s3_ready_e33", int'(ready), 0);
                     chk("s3_sysrst_e33", int'(sys_rst_n), 0);
                     chk("s3_pll_rst_e33", int'(pll_rst), 1);
        tick_to(34); chk("s3_lost_e34", int'(lock_lost), 0);
        tick_to(35); pll_locked = 1'b1;
        tick_to(45); chk("s3_ready_e45", int'(ready), 0);
        tick_to(46); chk("s3_ready_e46", int'(ready), 1);
                     chk("s3_retry_e46", int'(retry_cnt), 0);
        tick_to(50); restart = 1'b1;
        tick_to(51); chk("s5_ready_after_restart", int'(ready), 0);
                     chk("s5_pll_rst_after_restart", int'(pll_rst), 1);
        tick_to(55); restart = 1'b0;
        tick_to(58); chk("s5_held_pll_rst_e58", int'(pll_rst), 1);
        tick_to(59); chk("s5_held_pll_rst_e59", int'(pll_rst), 0);
        tick_to(68); chk("s5_ready_e68", int'(ready), 1);
        tick_to(70);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_run");

        // Asynchronous reset in the middle of STABLE.
        do_reset(1'b1);
        tick_to(8);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_stable");

        // One-cycle glitch on the lock pin during STABLE.
        do_reset(1'b1);
        tick_to(6);  pll_locked = 1'b0;
        tick_to(7);  pll_locked = 1'b1;
        tick_to(8);  chk("s4_retry_e8", int'(retry_cnt), 0);
                     chk("s4_pll_rst_e8", int'(pll_rst), 0);
        tick_to(9);  chk("s4_retry_e9", int'(retry_cnt), 1);
                     chk("s4_pll_rst_e9", int'(pll_rst), 1);
        while (ecnt < 21) begin
            tick();
            chk("s4_sysrst_low", int'(sys_rst_n), 0);
        end
        tick_to(22); chk("s4_sysrst_e22", int'(sys_rst_n), 1);

        // No lock at all: two retries then FAIL, then restart out of FAIL.
        do_reset(1'b0);
        tick_to(23); chk("s2_pll_rst_e23", int'(pll_rst), 0);
        tick_to(24); chk("s2_pll_rst_e24", int'(pll_rst), 1);
                     chk("s2_retry_e24", int'(retry_cnt), 1);
        tick_to(28); chk("s2_pll_rst_e28", int'(pll_rst), 0);
        tick_to(48); chk("s2_pll_rst_e48", int'(pll_rst), 1);
                     chk("s2_retry_e48", int'(retry_cnt), 2);
        tick_to(71); chk("s2_fail_e71", int'(fail), 0);
        tick_to(72); chk("s2_fail_e72", int'(fail), 1);
                     chk("s2_pll_rst_e72", int'(pll_rst), 1);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("s2_fail_hold", int'(fail), 1);
            chk("s2_pll_rst_hold", int'(pll_rst), 1);
            chk("s2_retry_hold", int'(retry_cnt), 2);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("s5_fail_cleared", int'(fail), 0);
        chk("s5_retry_cleared", int'(retry_cnt), 0);
        chk("s5_pll_rst_restart", int'(pll_rst), 1);
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
